// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract divisor if it fits.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, result used only while the divider iterates.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_n,
  output logic [W-1:0] quo_n
);

  // Shifted remainder carries one extra top bit, so the sign of the trial
  // lands in bit W+1 and a borrow is never confused with a large magnitude.
  logic [W+1:0] trial;
  logic         fits;

  // Trial subtraction and restore decision
  always_comb begin
    trial = {rem, quo[W-1]} - {2'b00, divisor};
    fits  = ~trial[W+1];
    rem_n = fits ? trial[W:0] : {rem[W-1:0], quo[W-1]};
    quo_n = {quo[W-2:0], fits};
  end

endmodule

// File: rtl/div.sv
// Signed sequential divider (lo = quotient, hi = remainder), one quotient bit per cycle.
// Latency: done pulse in the cycle after edge WIDTH+1; divide-by-zero flagged after edge 0.
// Backpressure: none; start requests during CALC/FIX are ignored. Option: DIV_SHORTCUT_EN.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             divControl,
  output logic             divStop,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             stop_q, stop_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // Operand magnitudes; the most negative value maps onto itself and is
  // then treated as an unsigned 2^(WIDTH-1).
  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
  end

  div_step #(
    .W (WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_n   (step_rem),
    .quo_n   (step_quo)
  );

  // Next-state logic: start/zero-check in IDLE, iterate in CALC, sign-fix in FIX
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stop_d    = 1'b0;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (divControl) begin
          if (b == '0) begin
            // Flag and finish immediately; hi/lo keep the last result.
            stop_d = 1'b1;
            zero_d = 1'b1;
          end else begin
            dvs_d     = abs_b;
            sgn_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            sgn_rem_d = a[WIDTH-1];
            rem_d     = '0;
            quo_d     = abs_a;
            cnt_d     = CNT_W'(WIDTH);
            state_d   = CALC;
`ifdef DIV_SHORTCUT_EN
            // Dividend smaller than divisor: quotient is zero, remainder is |a|.
            if (abs_a < abs_b) begin
              rem_d   = {1'b0, abs_a};
              quo_d   = '0;
              state_d = FIX;
            end
`endif
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Truncating quotient; remainder follows the dividend's sign.
        lo_d    = sgn_quo_q ? -quo_q : quo_q;
        hi_d    = sgn_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        stop_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset that aborts any division
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      stop_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      stop_q    <= stop_d;
      zero_q    <= zero_d;
    end
  end

  assign divStop = stop_q;
  assign divZero = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the signed sequential divider.
// Latency checked per operation, counted in edges from the start edge (edge 0).
// Expected values are hand-computed constants.
module tb_div;

  logic        clk;
  logic        Reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        divControl;
  logic        divStop;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;

`ifdef DIV_SHORTCUT_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 33;
`endif

  div dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .a          (a),
    .b          (b),
    .divControl (divControl),
    .divStop    (divStop),
    .divZero    (divZero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Start a division at edge 0, optionally re-pulse divControl with 1/1 at
  // poke_edge, then wait (bounded) for divStop and check latency and result.
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                     input logic exp_zero, input int poke_edge);
    int   lat;
    logic zero_seen;
    lat       = -1;
    zero_seen = 1'b0;
    @(negedge clk);
    a          = av;
    b          = bv;
    divControl = 1'b1;
    @(posedge clk);
    #1;
    divControl = 1'b0;
    a          = 32'hDEAD_BEEF;
    b          = 32'h0000_0003;
    if (divStop) begin
      lat       = 0;
      zero_seen = divZero;
    end
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == poke_edge) begin
        a          = 32'd1;
        b          = 32'd1;
        divControl = 1'b1;
      end
      @(posedge clk);
      #1;
      divControl = 1'b0;
      if (divStop) begin
        lat       = n;
        zero_seen = divZero;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " divZero"}, {31'd0, zero_seen}, {31'd0, exp_zero});
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    @(posedge clk);
    #1;
    check({tag, " divStop drop"}, {31'd0, divStop}, 32'd0);
    check({tag, " divZero drop"}, {31'd0, divZero}, 32'd0);
  endtask

  initial begin
    logic stop_seen;
    n_cmp      = 0;
    n_bad      = 0;
    Reset_n    = 1'b0;
    a          = '0;
    b          = '0;
    divControl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset divStop", {31'd0, divStop}, 32'd0);
    check("reset divZero", {31'd0, divZero}, 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;

    run("100/7",   32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0, 0);
    run("-7/2",    32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
    run("7/-2",    32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD,  32'd1,          1'b0, 0);
    run("-7/-2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  33, 32'd3,          32'hFFFF_FFFF,  1'b0, 0);
    run("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0,          1'b0, 0);
    run("max/1",   32'h7FFF_FFFF,  32'd1,          33, 32'h7FFF_FFFF,  32'd0,          1'b0, 0);
    run("9/4",     32'd9,          32'd4,          33, 32'd2,          32'd1,          1'b0, 0);
    run("5/0",     32'd5,          32'd0,           0, 32'd2,          32'd1,          1'b1, 0);

    // Reset at edge 10 aborts an in-flight division without a done pulse.
    @(negedge clk);
    a          = 32'd100;
    b          = 32'd7;
    divControl = 1'b1;
    @(posedge clk);
    #1;
    divControl = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b0;
    @(posedge clk);
    #1;
    Reset_n = 1'b1;
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    stop_seen = divStop;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      stop_seen = stop_seen | divStop;
    end
    check("abort no divStop", {31'd0, stop_seen}, 32'd0);

    run("100/7 after reset", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);
    run("100/7 poke",        32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 5);
    run("3/10",   32'd3,         32'd10, SHORT_LAT, 32'd0, 32'd3,         1'b0, 0);
    run("-3/10",  32'hFFFF_FFFD, 32'd10, SHORT_LAT, 32'd0, 32'hFFFF_FFFD, 1'b0, 0);
    run("0/5",    32'd0,         32'd5,  SHORT_LAT, 32'd0, 32'd0,         1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
